// File: rtl/wrr_pkt_sched_if.sv
// wrr_pkt_sched_if: valid/handshake, weight config and grant signals between scheduler and mux
interface wrr_pkt_sched_if #(
   parameter int IF_COUNT     = 3,
   parameter int SEL_WIDTH    = 2,
   parameter int WEIGHT_WIDTH = 4
);
   logic [IF_COUNT-1:0]              s_axis_tvalid;
   logic                             m_axis_tvalid;
   logic                             m_axis_tready;
   logic                             m_axis_tlast;
   logic [IF_COUNT*WEIGHT_WIDTH-1:0] cfg_weight;
   logic [SEL_WIDTH-1:0]             sel;
   logic                             en;
   logic [IF_COUNT-1:0]              grant;
   logic                             pkt_done;
   modport master (
      input  s_axis_tvalid, m_axis_tvalid, m_axis_tready, m_axis_tlast, cfg_weight,
      output sel, en, grant, pkt_done
   );
   modport slave (
      output s_axis_tvalid, m_axis_tvalid, m_axis_tready, m_axis_tlast, cfg_weight,
      input  sel, en, grant, pkt_done
   );
endinterface

// File: rtl/wrr_pkt_sched.sv
// wrr_pkt_sched: weighted round-robin packet scheduler; grant held for a whole packet,
// up to cfg_weight consecutive packets per port turn.
module wrr_pkt_sched #(
   parameter int IF_COUNT     = 3,
   parameter int SEL_WIDTH    = 2,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic clk,
   input  logic rst,
   wrr_pkt_sched_if.master bus
);
   typedef enum logic {ARB, PKT} state_t;
   state_t                  state_q, state_d;
   logic [SEL_WIDTH-1:0]    sel_q, sel_d, ptr_q, ptr_d, win;
   logic [WEIGHT_WIDTH-1:0] credit_q, credit_d, win_w;
   logic                    en_q, en_d, done_q, done_d, found;
   logic [IF_COUNT-1:0]     grant_q, grant_d, elig;
   always_comb
      for (int i = 0; i < IF_COUNT; i++)
         elig[i] = bus.s_axis_tvalid[i] && (bus.cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
   // second pass overrides the first, so ports at or after ptr beat wrapped ones
   always_comb begin
      found = 1'b0;
      win   = '0;
      win_w = '0;
      for (int i = IF_COUNT-1; i >= 0; i--)
         if (elig[i] && SEL_WIDTH'(i) < ptr_q) begin
            found = 1'b1;
            win   = SEL_WIDTH'(i);
            win_w = bus.cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         end
      for (int i = IF_COUNT-1; i >= 0; i--)
         if (elig[i] && SEL_WIDTH'(i) >= ptr_q) begin
            found = 1'b1;
            win   = SEL_WIDTH'(i);
            win_w = bus.cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         end
   end
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      en_d     = en_q;
      done_d   = 1'b0;
      if (state_q == ARB) begin
         if (credit_q != '0 && elig[sel_q]) begin
            credit_d = credit_q - WEIGHT_WIDTH'(1);
            en_d     = 1'b1;
            state_d  = PKT;
         end else if (found) begin
            sel_d    = win;
            credit_d = win_w - WEIGHT_WIDTH'(1);
            ptr_d    = (win == SEL_WIDTH'(IF_COUNT-1)) ? '0 : win + SEL_WIDTH'(1);
            en_d     = 1'b1;
            state_d  = PKT;
         end
      end else if (bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast) begin
         en_d    = 1'b0;
         done_d  = 1'b1;
         state_d = ARB;
      end
      grant_d = en_d ? IF_COUNT'(1) << sel_d : '0;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= ARB;
         sel_q    <= '0;
         ptr_q    <= '0;
         credit_q <= '0;
         en_q     <= 1'b0;
         done_q   <= 1'b0;
         grant_q  <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         en_q     <= en_d;
         done_q   <= done_d;
         grant_q  <= grant_d;
      end
   assign bus.sel      = sel_q;
   assign bus.en       = en_q;
   assign bus.grant    = grant_q;
   assign bus.pkt_done = done_q;
endmodule

// File: tb/tb_wrr_pkt_sched.sv
// tb_wrr_pkt_sched: directed test-plan scenarios plus randomized packets checked
// against a turn-based reference model of the weighted round-robin rules.
module tb_wrr_pkt_sched;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   w_m[3];
   int   ptr_m, cur_m, left_m;
   wrr_pkt_sched_if #(.IF_COUNT(3), .SEL_WIDTH(2), .WEIGHT_WIDTH(4)) bus ();
   wrr_pkt_sched #(.IF_COUNT(3), .SEL_WIDTH(2), .WEIGHT_WIDTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic set_w(input int a, input int b, input int c);
      w_m[0] = a;
      w_m[1] = b;
      w_m[2] = c;
      bus.cfg_weight = {4'(c), 4'(b), 4'(a)};
   endtask
   // a turn is a run of up to w packets from one port; left_m counts what remains of it
   function automatic int model_pick(input logic [2:0] v);
      if (left_m > 0 && v[cur_m] && w_m[cur_m] != 0) begin
         left_m--;
         return cur_m;
      end
      for (int j = 0; j < 3; j++) begin
         int k = (ptr_m + j) % 3;
         if (v[k] && w_m[k] != 0) begin
            cur_m  = k;
            left_m = w_m[k] - 1;
            ptr_m  = (k + 1) % 3;
            return k;
         end
      end
      return -1;
   endfunction
   task automatic do_reset();
      bus.s_axis_tvalid = '0;
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tready = 1'b1;
      bus.m_axis_tlast  = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_state", {28'd0, bus.en, bus.grant}, 32'd0);
      chk("rst_sel_done", {29'd0, bus.sel, bus.pkt_done}, 32'd0);
      rst = 1'b0;
      ptr_m  = 0;
      cur_m  = 0;
      left_m = 0;
   endtask
   task automatic run_pkt(input int exp, input logic [2:0] mask, input logic [2:0] mid_mask,
                          input int beats, input bit bubbles);
      int n = 0;
      int cyc = 0;
      bus.s_axis_tvalid = mask;
      if (exp < 0) begin
         bus.m_axis_tvalid = 1'b1;
         bus.m_axis_tready = 1'b1;
         bus.m_axis_tlast  = 1'b1;
         @(posedge clk);
         #1;
         chk("idle_no_grant", {28'd0, bus.en, bus.grant}, 32'd0);
         chk("idle_no_done", {31'd0, bus.pkt_done}, 32'd0);
         bus.m_axis_tvalid = 1'b0;
         bus.m_axis_tlast  = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      chk("grant_en_sel", {bus.en, bus.pkt_done, bus.sel}, {1'b1, 1'b0, 2'(exp)});
      chk("grant_onehot", {29'd0, bus.grant}, 32'(1 << exp));
      while (n < beats && cyc < 200) begin
         bus.m_axis_tvalid = bubbles ? ($urandom % 4 != 0) : 1'b1;
         bus.m_axis_tready = bubbles ? ($urandom % 4 != 0) : 1'b1;
         bus.m_axis_tlast  = (n == beats - 1);
         if (cyc == 1) bus.s_axis_tvalid = mid_mask;
         @(posedge clk);
         #1;
         if (bus.m_axis_tvalid && bus.m_axis_tready) n++;
         if (n < beats) chk("locked", {bus.en, bus.pkt_done, bus.sel}, {1'b1, 1'b0, 2'(exp)});
         cyc++;
      end
      if (n < beats) chk("beat_budget", 32'(n), 32'(beats));
      chk("release", {bus.en, bus.pkt_done, bus.sel}, {1'b0, 1'b1, 2'(exp)});
      chk("release_grant", {29'd0, bus.grant}, 32'd0);
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tlast  = 1'b0;
      bus.m_axis_tready = 1'b1;
   endtask
   initial begin
      int order_a[8] = '{0, 0, 1, 2, 0, 0, 1, 2};
      int order_b[6] = '{0, 1, 0, 0, 0, 1};
      logic [2:0] mask;
      int exp;
      set_w(1, 1, 1);
      do_reset();
      run_pkt(0, 3'b001, 3'b001, 4, 0);
      run_pkt(1, 3'b111, 3'b111, 1, 0);
      set_w(2, 1, 1);
      do_reset();
      for (int i = 0; i < 8; i++) run_pkt(order_a[i], 3'b111, 3'b111, 1, 0);
      set_w(1, 0, 1);
      do_reset();
      for (int i = 0; i < 4; i++) run_pkt((i % 2) * 2, 3'b111, 3'b111, 1, 0);
      set_w(1, 1, 1);
      do_reset();
      run_pkt(1, 3'b010, 3'b100, 3, 0);
      run_pkt(2, 3'b100, 3'b100, 1, 0);
      set_w(3, 1, 1);
      do_reset();
      run_pkt(order_b[0], 3'b011, 3'b011, 2, 0);
      run_pkt(order_b[1], 3'b010, 3'b010, 1, 0);
      for (int i = 2; i < 6; i++) run_pkt(order_b[i], 3'b011, 3'b011, 1, 0);
      set_w(1, 1, 1);
      do_reset();
      bus.s_axis_tvalid = 3'b100;
      @(posedge clk);
      #1;
      chk("pre_rst_sel", {30'd0, bus.sel}, 32'd2);
      bus.m_axis_tvalid = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst", {27'd0, bus.en, bus.sel, bus.grant == 3'b000}, {27'd0, 1'b0, 2'd0, 1'b1});
      #1;
      rst = 1'b0;
      bus.m_axis_tvalid = 1'b0;
      run_pkt(0, 3'b111, 3'b111, 1, 0);
      do_reset();
      for (int t = 0; t < 60; t++) begin
         if ($urandom % 5 == 0) set_w($urandom % 4, $urandom % 4, $urandom % 4);
         mask = 3'($urandom % 8);
         exp  = model_pick(mask);
         run_pkt(exp, mask, 3'($urandom % 8), $urandom_range(1, 4), 1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
